// File: rtl/lsu_bus_arbiter.sv
// Shares one req/gnt/rvalid RAM bus between instruction fetch and the LSU, one transaction in flight.
// Bus request one cycle after an IDLE request; gnt/rvalid/rdata pass through combinationally to the owner.
module lsu_bus_arbiter #(
    parameter int LSU_PRIO = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        ifu_req_i,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_gnt_o,
    output logic        ifu_rvalid_o,
    output logic [31:0] ifu_rdata_o,
    output logic        ifu_err_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_sel_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        stall_req_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);
    localparam logic       PRIO_FIXED = (LSU_PRIO != 0);

    state_t      state;
    logic        owner_lsu;
    logic        last_lsu;
    logic [7:0]  cnt;
    logic        lat_we;
    logic [3:0]  lat_sel;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic in_req;
    logic in_resp;
    logic gnt;
    logic done;
    logic tmo;
    logic pick_lsu;

    assign in_req  = (state == REQ);
    assign in_resp = (state == RESP);
    assign gnt     = in_req & bus_gnt_i;
    // A response only counts once the address phase has been accepted.
    assign done    = (in_req & bus_gnt_i & bus_rvalid_i) | (in_resp & bus_rvalid_i);
    assign tmo     = (in_req | in_resp) & (cnt == CNT_LAST) & ~done;

    // LSU wins when alone, when it has fixed priority, or when fetch was served last.
    assign pick_lsu = lsu_req_i & (~ifu_req_i | PRIO_FIXED | ~last_lsu);

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state     <= IDLE;
            owner_lsu <= 1'b0;
            last_lsu  <= 1'b0;
            cnt       <= 8'd0;
            lat_we    <= 1'b0;
            lat_sel   <= 4'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (ifu_req_i | lsu_req_i) begin
                        owner_lsu <= pick_lsu;
                        lat_we    <= pick_lsu ? lsu_we_i    : 1'b0;
                        lat_sel   <= pick_lsu ? lsu_sel_i   : 4'b1111;
                        lat_addr  <= pick_lsu ? lsu_addr_i  : ifu_addr_i;
                        lat_wdata <= pick_lsu ? lsu_wdata_i : 32'd0;
                        state     <= REQ;
                    end
                end
                REQ, RESP: begin
                    cnt <= cnt + 8'd1;
                    if (done | tmo) begin
                        last_lsu <= owner_lsu;
                        state    <= IDLE;
                    end else if (gnt) begin
                        state <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus_req_o   = in_req;
    assign bus_we_o    = lat_we;
    assign bus_sel_o   = lat_sel;
    assign bus_addr_o  = lat_addr;
    assign bus_wdata_o = lat_wdata;

    assign ifu_gnt_o    = gnt & ~owner_lsu;
    assign lsu_gnt_o    = gnt & owner_lsu;
    assign ifu_rvalid_o = done & ~owner_lsu;
    assign lsu_rvalid_o = done & owner_lsu;
    assign ifu_err_o    = tmo & ~owner_lsu;
    assign lsu_err_o    = tmo & owner_lsu;
    assign ifu_rdata_o  = ifu_rvalid_o ? bus_rdata_i : 32'd0;
    assign lsu_rdata_o  = lsu_rvalid_o ? bus_rdata_i : 32'd0;

    // Gated by reset so ctrl sees no stall while the arbiter is held in reset.
    assign stall_req_o = n_rst_i & lsu_req_i & ~lsu_rvalid_o & ~lsu_err_o;

endmodule
